// File: rtl/snake_cmd_decoder.sv
// UART byte to snake-game command decoder: queued directions, pause toggle, restart pulse.
// Define SNAKE_ARROW_EN to add the ANSI arrow-key (ESC [ A..D) parser with inter-byte timeout.
module snake_cmd_decoder #(
  parameter int         DEPTH       = 4,
  parameter logic [1:0] INIT_DIR    = 2'b01,
  parameter int         ESC_TIMEOUT = 250000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               dataRX,
  input  logic                     WR_RX,
  input  logic                     tick,
  output logic [1:0]               dir,
  output logic                     dir_changed,
  output logic                     paused,
  output logic                     restart,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic       pass_byte;
  logic       arrow_push;
  logic [1:0] arrow_dir;

  logic       cmd_push;
  logic [1:0] cmd_dir;
  logic       cmd_pause;
  logic       cmd_restart;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic          accept;

`ifdef SNAKE_ARROW_EN
  localparam int            TW    = $clog2(ESC_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(ESC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_ESC  = 2'd1,
    P_CSI  = 2'd2
  } parse_t;

  parse_t        state;
  parse_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;

  // Every byte inside a sequence re-arms the timer; silence for ESC_TIMEOUT cycles abandons it.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pass_byte  = 1'b0;
    arrow_push = 1'b0;
    arrow_dir  = 2'b00;
    case (state)
      P_IDLE: begin
        if (WR_RX) begin
          if (dataRX == 8'h1B) begin
            state_next = P_ESC;
            timer_next = '0;
          end else begin
            pass_byte = 1'b1;
          end
        end
      end
      P_ESC, P_CSI: begin
        if (WR_RX) begin
          timer_next = '0;
          state_next = P_IDLE;
          if (dataRX == 8'h1B) begin
            state_next = P_ESC;
          end else if (state == P_ESC) begin
            if (dataRX == 8'h5B) state_next = P_CSI;
          end else begin
            case (dataRX)
              8'h41: begin arrow_push = 1'b1; arrow_dir = 2'b00; end
              8'h42: begin arrow_push = 1'b1; arrow_dir = 2'b10; end
              8'h43: begin arrow_push = 1'b1; arrow_dir = 2'b01; end
              8'h44: begin arrow_push = 1'b1; arrow_dir = 2'b11; end
              default: ;
            endcase
          end
        end else if (timer == TLAST) begin
          state_next = P_IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= P_IDLE;
      timer <= '0;
    end else if (cmd_restart) begin
      state <= P_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end
`else
  assign pass_byte  = WR_RX;
  assign arrow_push = 1'b0;
  assign arrow_dir  = 2'b00;
`endif

  always_comb begin
    cmd_push    = arrow_push;
    cmd_dir     = arrow_dir;
    cmd_pause   = 1'b0;
    cmd_restart = 1'b0;
    if (WR_RX && pass_byte) begin
      case (dataRX)
        8'h77: begin cmd_push = 1'b1; cmd_dir = 2'b00; end
        8'h64: begin cmd_push = 1'b1; cmd_dir = 2'b01; end
        8'h73: begin cmd_push = 1'b1; cmd_dir = 2'b10; end
        8'h61: begin cmd_push = 1'b1; cmd_dir = 2'b11; end
        8'h70: cmd_pause   = 1'b1;
        8'h72: cmd_restart = 1'b1;
        default: ;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO alongside a pop is accepted.
  assign head   = mem[rd_ptr];
  assign full   = (fifo_count == CW'(DEPTH));
  assign empty  = (fifo_count == '0);
  assign pop    = tick && !paused && !empty && !cmd_restart;
  assign push   = cmd_push && (!full || pop);
  assign drop   = cmd_push && full && !pop;
  assign accept = pop && (head != dir) && (head != (dir ^ 2'b10));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_dir;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      dir         <= INIT_DIR;
      dir_changed <= 1'b0;
      paused      <= 1'b0;
      restart     <= 1'b0;
      overflow    <= 1'b0;
    end else if (cmd_restart) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      dir         <= INIT_DIR;
      dir_changed <= 1'b0;
      paused      <= 1'b0;
      restart     <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      restart     <= 1'b0;
      dir_changed <= accept;
      if (accept)    dir      <= head;
      if (cmd_pause) paused   <= ~paused;
      if (drop)      overflow <= 1'b1;
      if (push)      wr_ptr   <= wr_ptr + PW'(1);
      if (pop)       rd_ptr   <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule
